// File: rtl/rv32_e_mc_scheduler_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32_e_mc_scheduler_pkg : shared types for the multi-cycle op scheduler
// Revision: 1.0
// ---------------------------------------------------------------------------
package rv32_e_mc_scheduler_pkg;

    typedef enum logic [1:0] {
        MC_DIV   = 2'd0,
        MC_FDIV  = 2'd1,
        MC_FSQRT = 2'd2,
        MC_FMA   = 2'd3
    } mc_unit_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } mc_state_e;

    function automatic logic [3:0] unit_onehot(input mc_unit_e u);
        return 4'b0001 << u;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rv32_e_mc_hazard_cmp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32_e_mc_hazard_cmp : matches decode sources against the pending rd
// Revision: 1.0
// ---------------------------------------------------------------------------
module rv32_e_mc_hazard_cmp (
    input  logic [4:0]      rd_i,
    input  logic            rd_fp_i,
    input  logic [2:0][4:0] rs_i,
    input  logic [2:0]      src_fp_i,
    output logic            match_o
);

    logic [2:0] hit;

    for (genvar i = 0; i < 3; i++) begin : g_src
        assign hit[i] = (rs_i[i] == rd_i) && (src_fp_i[i] == rd_fp_i);
    end

    // Integer x0 is hardwired zero and never pending; f0 is a real register.
    assign match_o = (|hit) && (rd_fp_i || (rd_i != 5'd0));

endmodule
`default_nettype wire

// File: rtl/rv32_e_mc_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rv32_e_mc_scheduler : single-op scheduler for DIV/FDIV/FSQRT/FMA units
// Revision: 1.0
// ---------------------------------------------------------------------------
module rv32_e_mc_scheduler
    import rv32_e_mc_scheduler_pkg::*;
#(
    parameter int unsigned FMA_LATENCY = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       issue_valid_i,
    output logic       issue_ready_o,
    input  logic [1:0] issue_unit_i,
    input  logic [4:0] issue_rd_i,
    input  logic       issue_rd_fp_i,
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic [4:0] rs3_i,
    input  logic [2:0] src_fp_i,
    output logic       hazard_o,
    input  logic       flush_i,
    output logic [3:0] unit_start_o,
    input  logic [2:0] unit_done_i,
    output logic       unit_abort_o,
    input  logic       wb_free_i,
    output logic       wb_valid_o,
    output logic [4:0] wb_rd_o,
    output logic       wb_fp_o,
    output logic [1:0] wb_sel_o,
    output logic       busy_o
);

    localparam logic [3:0] FMA_CNT = 4'(FMA_LATENCY);

    mc_state_e  state_q, state_d;
    mc_unit_e   unit_q, unit_d;
    logic [4:0] rd_q, rd_d;
    logic       rd_fp_q, rd_fp_d;
    logic       pending_q, pending_d;
    logic [3:0] cnt_q, cnt_d;
    logic       first_q, first_d;

    logic handshake;
    logic load;
    logic done_sel;
    logic src_match;
    logic wb_done;
    logic repend;

    assign issue_ready_o = ((state_q == ST_IDLE) || ((state_q == ST_WB) && wb_free_i)) && !flush_i;
    assign handshake     = issue_valid_i && issue_ready_o;
    assign busy_o        = (state_q != ST_IDLE);
    assign wb_rd_o       = rd_q;
    assign wb_fp_o       = rd_fp_q;
    assign wb_sel_o      = unit_q;

    always_comb begin
        done_sel = 1'b0;
        case (unit_q)
            MC_DIV:   done_sel = unit_done_i[0];
            MC_FDIV:  done_sel = unit_done_i[1];
            MC_FSQRT: done_sel = unit_done_i[2];
            default:  done_sel = 1'b0;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        unit_d       = unit_q;
        rd_d         = rd_q;
        rd_fp_d      = rd_fp_q;
        pending_d    = pending_q;
        cnt_d        = cnt_q;
        first_d      = 1'b0;
        load         = 1'b0;
        unit_start_o = 4'b0000;
        unit_abort_o = 1'b0;
        wb_valid_o   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                load = handshake;
            end
            ST_RUN: begin
                if (first_q) begin
                    unit_start_o = unit_onehot(unit_q);
                end
                // Flush wins over a done arriving in the same cycle.
                if (flush_i) begin
                    unit_abort_o = 1'b1;
                    pending_d    = 1'b0;
                    state_d      = ST_IDLE;
                end else if (unit_q == MC_FMA) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = ST_WB;
                    end
                end else if (!first_q && done_sel) begin
                    state_d = ST_WB;
                end
            end
            ST_WB: begin
                wb_valid_o = 1'b1;
                if (wb_free_i) begin
                    pending_d = 1'b0;
                    state_d   = ST_IDLE;
                    load      = handshake;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                pending_d = 1'b0;
            end
        endcase

        if (load) begin
            unit_d    = mc_unit_e'(issue_unit_i);
            rd_d      = issue_rd_i;
            rd_fp_d   = issue_rd_fp_i;
            pending_d = 1'b1;
            cnt_d     = FMA_CNT;
            first_d   = 1'b1;
            state_d   = ST_RUN;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            unit_q    <= MC_DIV;
            rd_q      <= 5'd0;
            rd_fp_q   <= 1'b0;
            pending_q <= 1'b0;
            cnt_q     <= 4'd0;
            first_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            unit_q    <= unit_d;
            rd_q      <= rd_d;
            rd_fp_q   <= rd_fp_d;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            first_q   <= first_d;
        end
    end

    rv32_e_mc_hazard_cmp u_hazard_cmp (
        .rd_i     (rd_q),
        .rd_fp_i  (rd_fp_q),
        .rs_i     ({rs3_i, rs2_i, rs1_i}),
        .src_fp_i (src_fp_i),
        .match_o  (src_match)
    );

    // The hazard clears the cycle the writeback retires, unless the op being
    // accepted in that same cycle targets the same register again.
    assign wb_done  = (state_q == ST_WB) && wb_free_i;
    assign repend   = handshake && (issue_rd_i == rd_q) && (issue_rd_fp_i == rd_fp_q);
    assign hazard_o = pending_q && src_match && (!wb_done || repend);

endmodule
`default_nettype wire

// File: tb/tb_rv32_e_mc_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_rv32_e_mc_scheduler : directed scoreboard bench for rv32_e_mc_scheduler
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_rv32_e_mc_scheduler;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic       issue_valid_i;
    logic       issue_ready_o;
    logic [1:0] issue_unit_i;
    logic [4:0] issue_rd_i;
    logic       issue_rd_fp_i;
    logic [4:0] rs1_i, rs2_i, rs3_i;
    logic [2:0] src_fp_i;
    logic       hazard_o;
    logic       flush_i;
    logic [3:0] unit_start_o;
    logic [2:0] unit_done_i;
    logic       unit_abort_o;
    logic       wb_free_i;
    logic       wb_valid_o;
    logic [4:0] wb_rd_o;
    logic       wb_fp_o;
    logic [1:0] wb_sel_o;
    logic       busy_o;

    int checks   = 0;
    int failures = 0;

    // Expected writeback entry: {fp, sel[1:0], rd[4:0]}
    logic [7:0] sb[$];

    rv32_e_mc_scheduler #(.FMA_LATENCY(3)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .issue_valid_i (issue_valid_i),
        .issue_ready_o (issue_ready_o),
        .issue_unit_i  (issue_unit_i),
        .issue_rd_i    (issue_rd_i),
        .issue_rd_fp_i (issue_rd_fp_i),
        .rs1_i         (rs1_i),
        .rs2_i         (rs2_i),
        .rs3_i         (rs3_i),
        .src_fp_i      (src_fp_i),
        .hazard_o      (hazard_o),
        .flush_i       (flush_i),
        .unit_start_o  (unit_start_o),
        .unit_done_i   (unit_done_i),
        .unit_abort_o  (unit_abort_o),
        .wb_free_i     (wb_free_i),
        .wb_valid_o    (wb_valid_o),
        .wb_rd_o       (wb_rd_o),
        .wb_fp_o       (wb_fp_o),
        .wb_sel_o      (wb_sel_o),
        .busy_o        (busy_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic issue(input logic [1:0] unit, input logic [4:0] rd, input logic fp);
        issue_valid_i = 1'b1;
        issue_unit_i  = unit;
        issue_rd_i    = rd;
        issue_rd_fp_i = fp;
        sb.push_back({fp, unit, rd});
    endtask

    task automatic wb_accept();
        logic [7:0] e;
        wb_free_i = 1'b1;
        #1;
        chk("wb_valid_at_accept", 32'(wb_valid_o), 32'd1);
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("wb_rd", 32'(wb_rd_o), 32'(e[4:0]));
            chk("wb_sel", 32'(wb_sel_o), 32'(e[6:5]));
            chk("wb_fp", 32'(wb_fp_o), 32'(e[7]));
        end
    endtask

    task automatic wait_wb(input int bound);
        int n = 0;
        while (!wb_valid_o && n < bound) begin
            tick();
            #1;
            n++;
        end
        chk("wb_wait_bound", 32'(wb_valid_o), 32'd1);
    endtask

    initial begin
        rst_ni = 1'b0; issue_valid_i = 1'b0; issue_unit_i = 2'd0; issue_rd_i = 5'd0;
        issue_rd_fp_i = 1'b0; rs1_i = 5'd0; rs2_i = 5'd0; rs3_i = 5'd0; src_fp_i = 3'b000;
        flush_i = 1'b0; unit_done_i = 3'b000; wb_free_i = 1'b0;

        #12;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_wb_valid", 32'(wb_valid_o), 32'd0);
        chk("rst_start", 32'(unit_start_o), 32'd0);
        chk("rst_abort", 32'(unit_abort_o), 32'd0);
        chk("rst_hazard", 32'(hazard_o), 32'd0);
        chk("rst_wb_fields", 32'({wb_rd_o, wb_fp_o, wb_sel_o}), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        tick();
        chk("rst_ready", 32'(issue_ready_o), 32'd1);

        // DIV rd=x5, done four RUN cycles in
        issue(2'd0, 5'd5, 1'b0);
        #1;
        chk("div_ready", 32'(issue_ready_o), 32'd1);
        tick();
        issue_valid_i = 1'b0; rs1_i = 5'd5; src_fp_i = 3'b000;
        #1;
        chk("div_start", 32'(unit_start_o), 32'b0001);
        chk("div_busy", 32'(busy_o), 32'd1);
        chk("div_hazard", 32'(hazard_o), 32'd1);
        tick();
        chk("div_start_once", 32'(unit_start_o), 32'd0);
        tick();
        tick();
        unit_done_i = 3'b001;
        tick();
        unit_done_i = 3'b000;
        #1;
        chk("div_wb", 32'(wb_valid_o), 32'd1);
        wb_accept();
        tick();
        wb_free_i = 1'b0; rs1_i = 5'd0;
        #1;
        chk("div_idle", 32'(busy_o), 32'd0);
        chk("div_wb_clear", 32'(wb_valid_o), 32'd0);

        // FMA rd=f7: exactly three RUN cycles
        issue(2'd3, 5'd7, 1'b1);
        tick();
        issue_valid_i = 1'b0;
        #1;
        chk("fma_start", 32'(unit_start_o), 32'b1000);
        for (int i = 0; i < 3; i++) begin
            chk("fma_run_no_wb", 32'(wb_valid_o), 32'd0);
            chk("fma_run_busy", 32'(busy_o), 32'd1);
            tick();
            #1;
        end
        chk("fma_wb", 32'(wb_valid_o), 32'd1);
        wb_accept();
        tick();
        wb_free_i = 1'b0;

        // FDIV rd=f2: hazard file matching, done ignored in first RUN cycle
        issue(2'd1, 5'd2, 1'b1);
        tick();
        issue_valid_i = 1'b0; unit_done_i = 3'b010;
        rs2_i = 5'd2; src_fp_i = 3'b010;
        #1;
        chk("hz_fp_match", 32'(hazard_o), 32'd1);
        src_fp_i = 3'b000;
        #1;
        chk("hz_int_no_match", 32'(hazard_o), 32'd0);
        src_fp_i = 3'b010;
        tick();
        chk("fdiv_first_done_ignored", 32'(wb_valid_o), 32'd0);
        tick();
        unit_done_i = 3'b000;
        #1;
        chk("fdiv_wb", 32'(wb_valid_o), 32'd1);
        chk("hz_held_in_wb", 32'(hazard_o), 32'd1);
        wb_free_i = 1'b1;
        #1;
        chk("hz_drop_on_wb", 32'(hazard_o), 32'd0);
        wb_accept();
        tick();
        wb_free_i = 1'b0; rs2_i = 5'd0; src_fp_i = 3'b000;

        // DIV rd=x0: never a hazard; foreign done ignored
        issue(2'd0, 5'd0, 1'b0);
        tick();
        issue_valid_i = 1'b0; unit_done_i = 3'b110;
        #1;
        chk("hz_x0", 32'(hazard_o), 32'd0);
        tick();
        chk("foreign_done_ignored", 32'(wb_valid_o), 32'd0);
        unit_done_i = 3'b001;
        tick();
        unit_done_i = 3'b000;
        #1;
        wb_accept();
        tick();
        wb_free_i = 1'b0;

        // FMA rd=f0: f0 does match
        issue(2'd3, 5'd0, 1'b1);
        tick();
        issue_valid_i = 1'b0; src_fp_i = 3'b001;
        #1;
        chk("hz_f0", 32'(hazard_o), 32'd1);
        wait_wb(10);
        wb_accept();
        tick();
        wb_free_i = 1'b0;

        // FSQRT rd=f9: flush and done together
        issue(2'd2, 5'd9, 1'b1);
        tick();
        issue_valid_i = 1'b0; rs1_i = 5'd9;
        #1;
        chk("fsqrt_start", 32'(unit_start_o), 32'b0100);
        tick();
        flush_i = 1'b1; unit_done_i = 3'b100;
        #1;
        chk("flush_abort", 32'(unit_abort_o), 32'd1);
        chk("flush_not_ready", 32'(issue_ready_o), 32'd0);
        void'(sb.pop_back());
        tick();
        flush_i = 1'b0; unit_done_i = 3'b000;
        #1;
        chk("flush_idle", 32'(busy_o), 32'd0);
        chk("flush_no_wb", 32'(wb_valid_o), 32'd0);
        chk("flush_hz_clear", 32'(hazard_o), 32'd0);
        chk("flush_abort_once", 32'(unit_abort_o), 32'd0);
        rs1_i = 5'd0; src_fp_i = 3'b000;

        // Flush in IDLE blocks acceptance without abort
        flush_i = 1'b1; issue_valid_i = 1'b1; issue_unit_i = 2'd0; issue_rd_i = 5'd1;
        #1;
        chk("idle_flush_ready", 32'(issue_ready_o), 32'd0);
        chk("idle_flush_abort", 32'(unit_abort_o), 32'd0);
        tick();
        flush_i = 1'b0; issue_valid_i = 1'b0;
        #1;
        chk("idle_flush_stays_idle", 32'(busy_o), 32'd0);

        // DIV rd=x3 held in WB, then back-to-back re-pend of x3
        issue(2'd0, 5'd3, 1'b0);
        tick();
        issue_valid_i = 1'b0;
        tick();
        unit_done_i = 3'b001;
        tick();
        unit_done_i = 3'b000;
        #1;
        for (int i = 0; i < 5; i++) begin
            chk("wb_hold", 32'(wb_valid_o), 32'd1);
            if (i == 2) begin
                flush_i = 1'b1;
                #1;
                chk("wb_flush_keeps_wb", 32'(wb_valid_o), 32'd1);
                chk("wb_flush_not_ready", 32'(issue_ready_o), 32'd0);
            end
            tick();
            flush_i = 1'b0;
            #1;
        end
        rs1_i = 5'd3; src_fp_i = 3'b000;
        wb_free_i = 1'b1;
        #1;
        chk("b2b_ready", 32'(issue_ready_o), 32'd1);
        wb_accept();
        issue(2'd0, 5'd3, 1'b0);
        #1;
        chk("hz_repend", 32'(hazard_o), 32'd1);
        tick();
        wb_free_i = 1'b0; issue_valid_i = 1'b0;
        #1;
        chk("b2b_start", 32'(unit_start_o), 32'b0001);
        chk("b2b_no_wb", 32'(wb_valid_o), 32'd0);
        tick();
        unit_done_i = 3'b001;
        tick();
        unit_done_i = 3'b000;
        #1;
        wb_accept();
        tick();
        wb_free_i = 1'b0; rs1_i = 5'd0;

        // Reset mid-RUN
        issue(2'd2, 5'd11, 1'b1);
        tick();
        issue_valid_i = 1'b0; rs1_i = 5'd11; src_fp_i = 3'b001;
        tick();
        chk("pre_rst_busy", 32'(busy_o), 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("mrst_busy", 32'(busy_o), 32'd0);
        chk("mrst_abort", 32'(unit_abort_o), 32'd0);
        chk("mrst_start", 32'(unit_start_o), 32'd0);
        chk("mrst_hazard", 32'(hazard_o), 32'd0);
        chk("mrst_wb", 32'({wb_valid_o, wb_rd_o, wb_fp_o, wb_sel_o}), 32'd0);
        chk("mrst_ready", 32'(issue_ready_o), 32'd1);
        sb.delete();
        @(negedge clk_i);
        chk("mrst_abort_held", 32'(unit_abort_o), 32'd0);
        rst_ni = 1'b1;
        tick();
        chk("post_rst_idle", 32'(busy_o), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
